// File: rtl/powerup_pkg.sv
// Shared types for the powerup scheduler: slot and sweep state encodings,
// the per-slot record, and a half-open interval overlap helper.
package powerup_pkg;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_FALL = 2'd1,
    SLOT_REST = 2'd2
  } slot_state_t;

  typedef enum logic {
    SW_WAIT  = 1'b0,
    SW_SWEEP = 1'b1
  } sweep_state_t;

  typedef struct packed {
    slot_state_t state;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [1:0]  kind;
    logic [8:0]  counter;
  } slot_t;

  // [a_lo, a_hi) intersects [b_lo, b_hi)
  function automatic logic overlap(input logic [10:0] a_lo, input logic [10:0] a_hi,
                                   input logic [10:0] b_lo, input logic [10:0] b_hi);
    return (a_lo < b_hi) && (b_lo < a_hi);
  endfunction

endpackage

// File: rtl/powerup_hit.sv
// Combinational hit test of one sprite box against the current draw pixel,
// returning the pixel's offset inside the sprite ROM when it hits.
module powerup_hit #(
  parameter int SPRITE_W = 20,
  parameter int SPRITE_H = 28
) (
  input  logic       enable,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  output logic       hit,
  output logic [9:0] addr
);

  logic       in_x;
  logic       in_y;
  logic [9:0] off_x;
  logic [9:0] off_y;

  assign in_x  = (draw_x >= x) && ({1'b0, draw_x} < ({1'b0, x} + 11'(SPRITE_W)));
  assign in_y  = (draw_y >= y) && ({1'b0, draw_y} < ({1'b0, y} + 11'(SPRITE_H)));
  assign off_x = draw_x - x;
  assign off_y = draw_y - y;
  assign hit   = enable && in_x && in_y;
  assign addr  = hit ? (off_y * 10'(SPRITE_W) + off_x) : 10'd0;

endmodule

// File: rtl/powerup_scheduler.sv
// Powerup slot scheduler: spawns falling sprites, advances them once per frame,
// handles collection/expiry and resolves the sprite pixel. Optional macro: POWERUP_BLINK_EN.
//   state    | meaning
//   SW_WAIT  | idle between frames, waiting for frame_start
//   SW_SWEEP | visiting slot idx, one slot per cycle
module powerup_scheduler
  import powerup_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int SPRITE_W  = 20,
  parameter int SPRITE_H  = 28,
  parameter int FLOOR_Y   = 440,
  parameter int FALL_STEP = 2,
  parameter int LIFETIME  = 300,
  parameter int PLAYER_W  = 32,
  parameter int PLAYER_H  = 48
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic       spawn_req,
  input  logic [9:0] spawn_x,
  input  logic [9:0] spawn_y,
  input  logic [1:0] spawn_type,
  output logic       spawn_ack,
  output logic       spawn_drop,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  output logic       collect_valid,
  output logic [1:0] collect_type,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [9:0] rom_address,
  output logic       pix_valid,
  output logic [1:0] pix_type
);

  localparam int          IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [10:0] FLOOR_TOP = 11'(FLOOR_Y - SPRITE_H);
  localparam logic [8:0]  LAST_CNT  = 9'(LIFETIME - 1);

  slot_t            slots [NUM_SLOTS];
  sweep_state_t     sweep_state, sweep_next;
  logic [IDX_W-1:0] idx, idx_next;

  logic             spawn_found;
  logic [IDX_W-1:0] spawn_idx;

  slot_t            cur, upd;
  logic             collect_hit;
  logic [10:0]      fall_y;

  always_comb begin
    spawn_found = 1'b0;
    spawn_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slots[i].state == SLOT_IDLE) begin
        spawn_found = 1'b1;
        spawn_idx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      sweep_state <= SW_WAIT;
      idx         <= '0;
    end else begin
      sweep_state <= sweep_next;
      idx         <= idx_next;
    end
  end

  always_comb begin
    sweep_next = sweep_state;
    idx_next   = idx;
    case (sweep_state)
      SW_WAIT: begin
        if (frame_start) begin
          sweep_next = SW_SWEEP;
          idx_next   = '0;
        end
      end
      SW_SWEEP: begin
        if (idx == IDX_W'(NUM_SLOTS - 1)) begin
          sweep_next = SW_WAIT;
          idx_next   = '0;
        end else begin
          idx_next = idx + IDX_W'(1);
        end
      end
      default: sweep_next = SW_WAIT;
    endcase
  end

  // Collection beats movement and expiry for the visited slot.
  always_comb begin
    cur         = slots[idx];
    upd         = cur;
    collect_hit = 1'b0;
    fall_y      = {1'b0, cur.y} + 11'(FALL_STEP);
    if (cur.state != SLOT_IDLE) begin
      if (overlap({1'b0, cur.x}, {1'b0, cur.x} + 11'(SPRITE_W),
                  {1'b0, player_x}, {1'b0, player_x} + 11'(PLAYER_W)) &&
          overlap({1'b0, cur.y}, {1'b0, cur.y} + 11'(SPRITE_H),
                  {1'b0, player_y}, {1'b0, player_y} + 11'(PLAYER_H))) begin
        collect_hit = 1'b1;
        upd.state   = SLOT_IDLE;
      end else if (cur.state == SLOT_FALL) begin
        if (fall_y >= FLOOR_TOP) begin
          upd.y       = FLOOR_TOP[9:0];
          upd.state   = SLOT_REST;
          upd.counter = '0;
        end else begin
          upd.y = fall_y[9:0];
        end
      end else if (cur.counter == LAST_CNT) begin
        upd.state = SLOT_IDLE;
      end else begin
        upd.counter = cur.counter + 9'd1;
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
      spawn_ack     <= 1'b0;
      spawn_drop    <= 1'b0;
      collect_valid <= 1'b0;
      collect_type  <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (spawn_req && spawn_found && (spawn_idx == IDX_W'(i))) begin
          slots[i].state   <= SLOT_FALL;
          slots[i].x       <= spawn_x;
          slots[i].y       <= spawn_y;
          slots[i].kind    <= spawn_type;
          slots[i].counter <= '0;
        end else if ((sweep_state == SW_SWEEP) && (idx == IDX_W'(i))) begin
          slots[i] <= upd;
        end
      end
      spawn_ack     <= spawn_req && spawn_found;
      spawn_drop    <= spawn_req && !spawn_found;
      collect_valid <= (sweep_state == SW_SWEEP) && collect_hit;
      collect_type  <= ((sweep_state == SW_SWEEP) && collect_hit) ? cur.kind : 2'd0;
    end
  end

  logic [NUM_SLOTS-1:0] draw_en;
  logic [NUM_SLOTS-1:0] hit;
  logic [9:0]           hit_addr [NUM_SLOTS];

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      draw_en[i] = (slots[i].state != SLOT_IDLE);
`ifdef POWERUP_BLINK_EN
      // Expiring sprites flicker on a 16-frame period but stay collectable.
      if ((slots[i].state == SLOT_REST) && (slots[i].counter >= 9'(LIFETIME - 60)) &&
          slots[i].counter[3])
        draw_en[i] = 1'b0;
`endif
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_hit
    powerup_hit #(
      .SPRITE_W(SPRITE_W),
      .SPRITE_H(SPRITE_H)
    ) u_hit (
      .enable(draw_en[g]),
      .x     (slots[g].x),
      .y     (slots[g].y),
      .draw_x(DrawX),
      .draw_y(DrawY),
      .hit   (hit[g]),
      .addr  (hit_addr[g])
    );
  end

  logic       win_valid;
  logic [9:0] win_addr;
  logic [1:0] win_type;

  always_comb begin
    win_valid = 1'b0;
    win_addr  = '0;
    win_type  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_valid = 1'b1;
        win_addr  = hit_addr[i];
        win_type  = slots[i].kind;
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      pix_valid   <= 1'b0;
      pix_type    <= '0;
      rom_address <= '0;
    end else begin
      pix_valid   <= win_valid;
      pix_type    <= win_type;
      rom_address <= win_addr;
    end
  end

endmodule

// File: tb/tb_powerup_scheduler.sv
// Self-checking bench for powerup_scheduler: directed scenarios plus random
// spawn/frame/probe traffic against a frame-level behavioural model.
module tb_powerup_scheduler;

  localparam int NS = 4, SW = 20, SH = 28, FLOOR_TOP = 412, STEP = 2, LIFE = 300;
  localparam int PW = 32, PH = 48;

  logic       vga_clk, reset_n, frame_start, spawn_req;
  logic [9:0] spawn_x, spawn_y, player_x, player_y, DrawX, DrawY;
  logic [1:0] spawn_type, collect_type, pix_type;
  logic       spawn_ack, spawn_drop, collect_valid, pix_valid;
  logic [9:0] rom_address;

  powerup_scheduler dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .frame_start(frame_start),
    .spawn_req(spawn_req), .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_type(spawn_type),
    .spawn_ack(spawn_ack), .spawn_drop(spawn_drop),
    .player_x(player_x), .player_y(player_y),
    .collect_valid(collect_valid), .collect_type(collect_type),
    .DrawX(DrawX), .DrawY(DrawY), .rom_address(rom_address),
    .pix_valid(pix_valid), .pix_type(pix_type)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  int checks = 0;
  int failures = 0;

  // model: 0 idle, 1 falling, 2 resting
  int m_state [NS];
  int m_x [NS], m_y [NS], m_type [NS], m_cnt [NS];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_state[i] = 0; m_x[i] = 0; m_y[i] = 0; m_type[i] = 0; m_cnt[i] = 0;
    end
  endtask

  function automatic bit touches(input int i);
    int px = int'(player_x);
    int py = int'(player_y);
    return (m_x[i] < px + PW) && (px < m_x[i] + SW) && (m_y[i] < py + PH) && (py < m_y[i] + SH);
  endfunction

  task automatic model_frame(output int col_q[$]);
    col_q = {};
    for (int i = 0; i < NS; i++) begin
      if (m_state[i] == 0) continue;
      if (touches(i)) begin
        col_q.push_back(m_type[i]);
        m_state[i] = 0;
      end else if (m_state[i] == 1) begin
        if (m_y[i] + STEP >= FLOOR_TOP) begin
          m_y[i] = FLOOR_TOP; m_state[i] = 2; m_cnt[i] = 0;
        end else m_y[i] = m_y[i] + STEP;
      end else if (m_cnt[i] == LIFE - 1) m_state[i] = 0;
      else m_cnt[i]++;
    end
  endtask

  task automatic model_pix(input int dx, input int dy, output int v, output int t, output int a);
    v = 0; t = 0; a = 0;
    for (int i = 0; i < NS; i++) begin
      if (m_state[i] != 0 && dx >= m_x[i] && dx < m_x[i] + SW &&
          dy >= m_y[i] && dy < m_y[i] + SH) begin
        v = 1; t = m_type[i]; a = (dy - m_y[i]) * SW + (dx - m_x[i]);
        break;
      end
    end
  endtask

  task automatic model_load(input int sx, input int sy, input int st, output int slot);
    slot = -1;
    for (int i = 0; i < NS; i++) if (m_state[i] == 0 && slot < 0) slot = i;
    if (slot >= 0) begin
      m_state[slot] = 1; m_x[slot] = sx; m_y[slot] = sy; m_type[slot] = st; m_cnt[slot] = 0;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic do_spawn(input int sx, input int sy, input int st);
    int slot;
    model_load(sx, sy, st, slot);
    spawn_x = 10'(sx); spawn_y = 10'(sy); spawn_type = 2'(st);
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    chk("spawn_ack", int'(spawn_ack), int'(slot >= 0));
    chk("spawn_drop", int'(spawn_drop), int'(slot < 0));
    tick();
    chk("spawn_ack_clear", int'(spawn_ack | spawn_drop), 0);
  endtask

  task automatic do_frame(input int len);
    int exp_q[$];
    int got_q[$];
    model_frame(exp_q);
    frame_start = 1'b1;
    for (int c = 0; c < NS + 3; c++) begin
      if (c == len) frame_start = 1'b0;
      tick();
      if (collect_valid) got_q.push_back(int'(collect_type));
    end
    frame_start = 1'b0;
    chk("collect_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk("collect_type", got_q[i], exp_q[i]);
  endtask

  task automatic probe(input int dx, input int dy);
    int v, t, a;
    model_pix(dx & 1023, dy & 1023, v, t, a);
    DrawX = 10'(dx); DrawY = 10'(dy);
    tick();
    chk("pix_valid", int'(pix_valid), v);
    chk("pix_type", int'(pix_type), t);
    chk("rom_address", int'(rom_address), a);
  endtask

  task automatic player_far();
    player_x = 10'd990; player_y = 10'd0;
  endtask

  initial begin
    int live [$];
    int s, slot;
    reset_n = 1'b0; frame_start = 1'b0; spawn_req = 1'b0;
    spawn_x = '0; spawn_y = '0; spawn_type = '0; DrawX = '0; DrawY = '0;
    player_far();
    model_reset();
    repeat (3) tick();
    chk("rst_spawn_ack", int'(spawn_ack), 0);
    chk("rst_spawn_drop", int'(spawn_drop), 0);
    chk("rst_collect_valid", int'(collect_valid), 0);
    chk("rst_collect_type", int'(collect_type), 0);
    chk("rst_pix_valid", int'(pix_valid), 0);
    chk("rst_pix_type", int'(pix_type), 0);
    chk("rst_rom_address", int'(rom_address), 0);
    reset_n = 1'b1;
    tick();

    // spawn then five frames: 50 -> 60
    do_spawn(100, 50, 1);
    repeat (5) do_frame(1);
    probe(100, 60);
    chk("fall5_top_visible", int'(pix_valid), 1);
    probe(100, 59);

    // pool exhaustion
    do_reset();
    for (int i = 0; i < 5; i++) do_spawn(100 + 40 * i, 10, i & 3);

    // clamp to floor and expiry
    do_reset();
    do_spawn(200, 400, 2);
    repeat (7) do_frame(1);
    probe(200, 412);
    chk("clamp_rest_type", int'(pix_type), 2);
    probe(200, 411);
    repeat (298) do_frame(1 + (int'($urandom) & 3));
    probe(200, 412);
    chk("rest_before_expiry", int'(pix_valid), 1);
    do_frame(1);
    probe(200, 412);
    chk("expired", int'(pix_valid), 0);

    // pixel priority
    do_reset();
    do_spawn(100, 400, 1);
    do_spawn(110, 400, 3);
    repeat (6) do_frame(1);
    probe(105, 415);
    chk("prio_addr", int'(rom_address), 65);
    chk("prio_type", int'(pix_type), 1);
    probe(125, 415);
    chk("slot1_addr", int'(rom_address), 75);

    // collection
    do_reset();
    do_spawn(100, 400, 2);
    repeat (6) do_frame(1);
    player_x = 10'd90; player_y = 10'd400;
    do_frame(1);
    player_far();
    probe(105, 415);
    chk("collected_gone", int'(pix_valid), 0);

    // spawn landing in the cycle its slot is visited: no update that frame
    do_reset();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    spawn_x = 10'd300; spawn_y = 10'd100; spawn_type = 2'd1; spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    model_load(300, 100, 1, slot);
    chk("visit_spawn_ack", int'(spawn_ack), 1);
    repeat (5) tick();
    probe(300, 100);
    chk("visit_spawn_y", int'(rom_address), 0);
    // spawn together with frame_start: slot visited afterwards, so it moves
    do_reset();
    spawn_x = 10'd300; spawn_y = 10'd100; spawn_type = 2'd3; spawn_req = 1'b1;
    frame_start = 1'b1;
    tick();
    spawn_req = 1'b0; frame_start = 1'b0;
    model_load(300, 100, 3, slot);
    begin
      int dq[$];
      model_frame(dq);
    end
    repeat (6) tick();
    probe(300, 102);
    chk("pre_visit_spawn_moved", int'(pix_valid), 1);
    probe(300, 101);

    // reset mid-sweep, with a spawn attempted while reset is low
    do_reset();
    do_spawn(100, 200, 1);
    do_spawn(400, 300, 2);
    DrawX = 10'd105; DrawY = 10'd203;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    chk("pre_rst_pix_valid", int'(pix_valid), 1);
    reset_n = 1'b0;
    spawn_x = 10'd500; spawn_y = 10'd150; spawn_type = 2'd3; spawn_req = 1'b1;
    tick();
    chk("midrst_pix_valid", int'(pix_valid), 0);
    chk("midrst_rom_address", int'(rom_address), 0);
    chk("midrst_pix_type", int'(pix_type), 0);
    chk("midrst_spawn_ack", int'(spawn_ack), 0);
    chk("midrst_collect_valid", int'(collect_valid), 0);
    reset_n = 1'b1; spawn_req = 1'b0;
    model_reset();
    probe(500, 150);
    probe(105, 203);
    probe(400, 302);
    do_spawn(600, 20, 2);
    do_frame(1);
    probe(600, 22);
    chk("post_rst_frame", int'(pix_valid), 1);

    // random traffic
    do_reset();
    for (int it = 0; it < 400; it++) begin
      live = {};
      for (int i = 0; i < NS; i++) if (m_state[i] != 0) live.push_back(i);
      case ($urandom_range(0, 9))
        0, 1, 2: do_spawn($urandom_range(0, 900), $urandom_range(0, 430), $urandom_range(0, 3));
        3, 4, 5: do_frame($urandom_range(1, 4));
        6, 7, 8: begin
          if (live.size() > 0) begin
            s = live[$urandom_range(0, live.size() - 1)];
            probe(m_x[s] + $urandom_range(0, 29) - 5, m_y[s] + $urandom_range(0, 37) - 5);
          end else probe($urandom_range(0, 1023), $urandom_range(0, 1023));
        end
        default: begin
          if (live.size() > 0 && $urandom_range(0, 1) == 1) begin
            s = live[$urandom_range(0, live.size() - 1)];
            player_x = 10'((m_x[s] + $urandom_range(0, 60) - 40) & 1023);
            player_y = 10'((m_y[s] + $urandom_range(0, 80) - 60) & 1023);
          end else player_far();
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
